// File: rtl/uart_tx_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg_if
//
// Bundles the character handshake, the per-frame configuration and the
// serial line of uart_tx_cfg.
//
//   tx_start      request to send din (honoured only when the transmitter is idle)
//   din[7:0]      character, sent LSB first
//   data_sel[1:0] data length: 00=5, 01=6, 10=7, 11=8 bits
//   parity_sel    parity: 00=none, 01=even, 10=odd, 11=none
//   stop_sel      stop length: 00=1, 01=1.5, 10=2, 11=2 bits
//   tx            serial line, idle high
//   tx_busy       frame in progress
//   tx_done_tick  one-cycle pulse on the last stop baud_tick
//
// master: the FIFO/control-register side that requests characters.
// slave : the transmitter itself.
// ---------------------------------------------------------------------------
interface uart_tx_cfg_if;
  logic       tx_start;
  logic [7:0] din;
  logic [1:0] data_sel;
  logic [1:0] parity_sel;
  logic [1:0] stop_sel;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;

  modport master (
    output tx_start, din, data_sel, parity_sel, stop_sel,
    input  tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_start, din, data_sel, parity_sel, stop_sel,
    output tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg
//
// Runtime-configurable UART transmitter. Sends one character per accepted
// tx_start, timing every bit from an external oversampling strobe. Each
// frame supports 5-8 data bits, none/even/odd parity and 1, 1.5 or 2 stop
// bits. The configuration is captured at acceptance, so the control
// register may change mid-frame without corrupting the character on the line.
//
// Parameters:
//   OVERSAMPLE  baud_ticks per bit period (even, >= 4)
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset (abandons any frame, line high)
//   baud_tick  one-cycle oversampling strobe
//   bus        uart_tx_cfg_if.slave (tx_start, din, *_sel, tx, tx_busy,
//              tx_done_tick)
//
// Build option:
//   UART_TX_PARITY_EN  compiles in the PARITY state and parity generation.
//                      Without it, parity_sel is ignored and every frame is
//                      sent without a parity bit.
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int OVERSAMPLE = 16
) (
  input logic          clk,
  input logic          reset_n,
  input logic          baud_tick,
  uart_tx_cfg_if.slave bus
);

  localparam int TW = $clog2(2 * OVERSAMPLE);

  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(3 * OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    len_q, len_d;
  logic [1:0]    stop_q, stop_d;
  logic          tx_q, tx_d;
  logic          busy_q;
  logic          done;

  logic          bit_end;
  logic [2:0]    last_bit;
  logic [TW-1:0] stop_last;

`ifdef UART_TX_PARITY_EN
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic [7:0]    din_mask;
  logic          din_parity;

  // Parity is taken from the unshifted character at acceptance because the
  // shift register no longer holds the data by the time PARITY is reached.
  always_comb begin
    din_mask   = 8'hFF >> (2'd3 - bus.data_sel);
    din_parity = ^(bus.din & din_mask);
  end
`else
  logic unused_parity_sel;
  assign unused_parity_sel = ^bus.parity_sel;
`endif

  assign bit_end  = baud_tick && (tick_q == BIT_LAST);
  assign last_bit = 3'd4 + {1'b0, len_q};

  always_comb begin
    case (stop_q)
      2'b00:   stop_last = BIT_LAST;
      2'b01:   stop_last = STOP15_LAST;
      default: stop_last = STOP2_LAST;
    endcase
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    len_d   = len_q;
    stop_d  = stop_q;
    done    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.tx_start) begin
          shift_d = bus.din;
          len_d   = bus.data_sel;
          stop_d  = bus.stop_sel;
          tick_d  = '0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_en_d  = (bus.parity_sel == 2'b01) || (bus.parity_sel == 2'b10);
          par_bit_d = (bus.parity_sel == 2'b10) ? ~din_parity : din_parity;
`endif
        end
      end

      S_START: begin
        if (bit_end) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else if (baud_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == last_bit) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            // The counter stops at the last index rather than wrapping.
            bit_d = bit_q + 1'b1;
          end
        end else if (baud_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          state_d = S_STOP;
        end else if (baud_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (baud_tick && (tick_q == stop_last)) begin
          done    = 1'b1;
          tick_d  = '0;
          state_d = S_IDLE;
        end else if (baud_tick) begin
          tick_d = tick_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The line value is decoded from the next state so the registered tx
  // changes on the same edge as the state it belongs to.
  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      len_q   <= '0;
      stop_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      len_q   <= len_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg
//
// Directed bench for uart_tx_cfg with OVERSAMPLE=16. baud_tick is driven by
// the bench (one tick every second clock). Each frame's line pattern is
// given by hand as a bit list (start bit first) plus a stop length in ticks;
// tx, tx_busy and tx_done_tick are compared on every tick. Frames follow
// each other with a one-clock gap, so back-to-back acceptance is exercised
// throughout.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic clk;
  logic reset_n;
  logic baud_tick;

  int vectors;
  int miscompares;

  uart_tx_cfg_if bus ();

  uart_tx_cfg #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .baud_tick (baud_tick),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the transmitter idle. Sends one frame and
  // returns in the first idle cycle after it, so a following call lands its
  // tx_start in the cycle right after tx_done_tick.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] ds,
                           input logic [1:0] ps, input logic [1:0] ss,
                           input logic [11:0] exp_bits, input int nbits,
                           input int stop_ticks, input bit accept_tick,
                           input int poke_tick);
    int   total;
    int   done_cnt;
    logic exp_tx;
    total    = nbits * OS + stop_ticks;
    done_cnt = 0;

    bus.din        = d;
    bus.data_sel   = ds;
    bus.parity_sel = ps;
    bus.stop_sel   = ss;
    bus.tx_start   = 1'b1;
    baud_tick      = accept_tick;
    @(negedge clk);
    bus.tx_start   = 1'b0;
    baud_tick      = 1'b0;
    // Scramble the inputs: the frame must come from the captured copy.
    bus.din        = ~d;
    bus.data_sel   = ~ds;
    bus.parity_sel = ~ps;
    bus.stop_sel   = ~ss;
    #1;
    check($sformatf("%s start tx", tag), 16'(bus.tx), 16'd0);
    check($sformatf("%s start busy", tag), 16'(bus.tx_busy), 16'd1);

    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      baud_tick = 1'b1;
      if (i == poke_tick) begin
        bus.din      = 8'hFF;
        bus.tx_start = 1'b1;
      end
      #1;
      exp_tx = (i < nbits * OS) ? exp_bits[i / OS] : 1'b1;
      check($sformatf("%s tx@%0d", tag, i), 16'(bus.tx), 16'(exp_tx));
      check($sformatf("%s busy@%0d", tag, i), 16'(bus.tx_busy), 16'd1);
      check($sformatf("%s done@%0d", tag, i), 16'(bus.tx_done_tick), 16'(i == total - 1));
      if (bus.tx_done_tick) done_cnt++;
      @(negedge clk);
      baud_tick    = 1'b0;
      bus.tx_start = 1'b0;
    end

    #1;
    check($sformatf("%s done count", tag), 16'(done_cnt), 16'd1);
    check($sformatf("%s end busy", tag), 16'(bus.tx_busy), 16'd0);
    check($sformatf("%s end tx", tag), 16'(bus.tx), 16'd1);
    check($sformatf("%s end done", tag), 16'(bus.tx_done_tick), 16'd0);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    baud_tick      = 1'b0;
    bus.tx_start   = 1'b0;
    bus.din        = 8'h00;
    bus.data_sel   = 2'b00;
    bus.parity_sel = 2'b00;
    bus.stop_sel   = 2'b00;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset tx", 16'(bus.tx), 16'd1);
    check("reset busy", 16'(bus.tx_busy), 16'd0);
    check("reset done", 16'(bus.tx_done_tick), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle tx", 16'(bus.tx), 16'd1);
    check("idle busy", 16'(bus.tx_busy), 16'd0);

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1 then 16 stop ticks (160 total).
    run_frame("8N1_A5", 8'hA5, 2'b11, 2'b00, 2'b00, 12'h14A, 9, 16, 1'b0, -1);

`ifdef UART_TX_PARITY_EN
    // 7E1 0xC1: start, 1,0,0,0,0,0,1, parity 0, one stop.
    run_frame("7E1_C1", 8'hC1, 2'b10, 2'b01, 2'b00, 12'h082, 9, 16, 1'b0, -1);
    // 5O2 0x1F: start, five 1s, parity 0, 32 stop ticks.
    run_frame("5O2_1F", 8'h1F, 2'b00, 2'b10, 2'b10, 12'h03E, 7, 32, 1'b0, -1);
    // 6E2 0x2A (stop_sel 11): data 0,1,0,1,0,1, parity 1; baud_tick at accept.
    run_frame("6E2_2A", 8'h2A, 2'b01, 2'b01, 2'b11, 12'h0D4, 8, 32, 1'b1, -1);
`else
    // Parity build option absent: parity_sel has no effect.
    run_frame("7E1_C1", 8'hC1, 2'b10, 2'b01, 2'b00, 12'h082, 8, 16, 1'b0, -1);
    // 5O2 0x1F without parity: 6*16 + 32 = 128 ticks.
    run_frame("5O2_1F", 8'h1F, 2'b00, 2'b10, 2'b10, 12'h03E, 6, 32, 1'b0, -1);
    run_frame("6E2_2A", 8'h2A, 2'b01, 2'b01, 2'b11, 12'h054, 7, 32, 1'b1, -1);
`endif

    // 8N1.5 0x00: nine low bits, 24 stop ticks.
    run_frame("8N15_00", 8'h00, 2'b11, 2'b00, 2'b01, 12'h000, 9, 24, 1'b0, -1);

    // 8N2 0x3C with tx_start + 0xFF poked during data bit 2: ignored.
    run_frame("8N2_3C_poke", 8'h3C, 2'b11, 2'b00, 2'b10, 12'h078, 9, 32, 1'b0, 55);

    // Reset during data bit 3 of an 8N1 0xA5 frame.
    bus.din        = 8'hA5;
    bus.data_sel   = 2'b11;
    bus.parity_sel = 2'b00;
    bus.stop_sel   = 2'b00;
    bus.tx_start   = 1'b1;
    @(negedge clk);
    bus.tx_start   = 1'b0;
    for (int i = 0; i < 69; i++) begin
      @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
    #1;
    check("pre-reset tx bit3", 16'(bus.tx), 16'd0);
    check("pre-reset busy", 16'(bus.tx_busy), 16'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset tx", 16'(bus.tx), 16'd1);
    check("async reset busy", 16'(bus.tx_busy), 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    check("post-reset tx", 16'(bus.tx), 16'd1);
    check("post-reset busy", 16'(bus.tx_busy), 16'd0);

    // 8N1 0x55 after reset: 0,1,0,1,0,1,0,1,0 then stop.
    run_frame("8N1_55", 8'h55, 2'b11, 2'b00, 2'b00, 12'h0AA, 9, 16, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
